// File: rtl/noc_pkg.sv
// Shared constants and helpers for the 1D NoC line router: port indices,
// flit field offsets, the destination routing rule and round-robin stepping.
package noc_pkg;

    localparam int PORT_E    = 0;
    localparam int PORT_W    = 1;
    localparam int PORT_L    = 2;
    localparam int NUM_PORTS = 3;

    localparam int VALID_BIT = 0;
    localparam int ADDR_LSB  = 1;

    // Destinations above this node travel east, below travel west.
    function automatic logic [1:0] route(input int unsigned dst, input int unsigned local_ip);
        if (dst == local_ip) begin
            return 2'(PORT_L);
        end else if (dst > local_ip) begin
            return 2'(PORT_E);
        end else begin
            return 2'(PORT_W);
        end
    endfunction

    // (base + step) mod NUM_PORTS for base, step in 0..2.
    function automatic logic [1:0] rr_next(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// First-word-fall-through FIFO: dout shows the oldest entry whenever !empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module noc_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/noc_router_rr.sv
// Three-port (E, W, L) line router: one FIFO per input, one round-robin
// arbiter plus output register per output, u-turn flits dropped and flagged.
module noc_router_rr
    import noc_pkg::*;
#(
    parameter int          WIDTH    = 16,
    parameter int          DEPTH    = 32,
    parameter int          ADDR_W   = 2,
    parameter int unsigned LOCAL_IP = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           in_valid,
    input  logic [NUM_PORTS*WIDTH-1:0]     in_data,
    output logic [NUM_PORTS-1:0]           in_ready,
    output logic [NUM_PORTS-1:0]           out_valid,
    output logic [NUM_PORTS*WIDTH-1:0]     out_data,
    input  logic [NUM_PORTS-1:0]           out_ready,
    output logic [NUM_PORTS-1:0]           err_uturn
);

    // Every link is valid/ready: a flit moves on a cycle where both are high,
    // the sender holds valid and data stable until then, and ready never
    // depends combinationally on valid (in_ready comes only from FIFO state).

    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] uturn;
    logic [WIDTH-1:0]     head [NUM_PORTS];
    logic [1:0]           dest [NUM_PORTS];
    logic [NUM_PORTS-1:0] req  [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant [NUM_PORTS];
    logic [NUM_PORTS-1:0] can_load;

    assign in_ready = ~fifo_full;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        logic err_q;

        assign push[p] = in_valid[p] && !fifo_full[p] && in_data[p*WIDTH + VALID_BIT];

        noc_sync_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk  (clk),
            .reset(reset),
            .push (push[p]),
            .pop  (pop[p]),
            .din  (in_data[p*WIDTH +: WIDTH]),
            .dout (head[p]),
            .full (fifo_full[p]),
            .empty(fifo_empty[p])
        );

        assign dest[p]  = route(32'(head[p][ADDR_W:ADDR_LSB]), LOCAL_IP);
        assign uturn[p] = !fifo_empty[p] &&
                          ((p == PORT_E && dest[p] == 2'(PORT_E)) ||
                           (p == PORT_W && dest[p] == 2'(PORT_W)));

        for (genvar o = 0; o < NUM_PORTS; o++) begin : g_req
            assign req[o][p] = !fifo_empty[p] && !uturn[p] && (dest[p] == 2'(o));
        end

        // A u-turn head leaves without a grant; each input requests one output only.
        assign pop[p] = uturn[p] || grant[PORT_E][p] || grant[PORT_W][p] || grant[PORT_L][p];

        always_ff @(posedge clk) begin
            if (reset) begin
                err_q <= 1'b0;
            end else if (uturn[p]) begin
                err_q <= 1'b1;
            end
        end

        assign err_uturn[p] = err_q;
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [1:0]           ptr_q;
        logic [NUM_PORTS-1:0] gnt;
        logic                 ld;
        logic [1:0]           win;
        logic [WIDTH-1:0]     ld_data;
        logic                 valid_q;
        logic [WIDTH-1:0]     data_q;

        assign can_load[o] = !valid_q || out_ready[o];

        // Scan from ptr_q upward with wrap; the first requester wins.
        always_comb begin
            gnt     = '0;
            ld      = 1'b0;
            win     = 2'd0;
            ld_data = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (can_load[o] && !ld && req[o][rr_next(ptr_q, 2'(k))]) begin
                    ld       = 1'b1;
                    win      = rr_next(ptr_q, 2'(k));
                    gnt[win] = 1'b1;
                    ld_data  = head[win];
                end
            end
        end

        assign grant[o] = gnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                ptr_q   <= 2'd0;
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (ld) begin
                ptr_q   <= rr_next(win, 2'd1);
                valid_q <= 1'b1;
                data_q  <= ld_data;
            end else if (out_ready[o]) begin
                valid_q <= 1'b0;
            end
        end

        assign out_valid[o]                = valid_q;
        assign out_data[o*WIDTH +: WIDTH]  = data_q;
    end

endmodule

// File: tb/tb_noc_router_rr.sv
// Bench for noc_router_rr: directed scenarios plus random traffic, checked by
// a per-path expected-flit scoreboard and a monitor decoupled from the drivers.
module tb_noc_router_rr;

    localparam int          WIDTH    = 16;
    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 2;
    localparam int unsigned LOCAL_IP = 1;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic [2:0]  in_valid  = '0;
    logic [47:0] in_data   = '0;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [47:0] out_data;
    logic [2:0]  out_ready = '0;
    logic [2:0]  err_uturn;

    noc_router_rr #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .LOCAL_IP(LOCAL_IP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .err_uturn(err_uturn)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        int src;
        int seq;
        int cyc;
        int lat;
    } rec_t;

    logic [15:0] exp_q [9][$];   // index = src*3 + out
    rec_t        log_q [3][$];
    int          sent_cyc [int];
    logic [2:0]  err_model = '0;
    logic [2:0]  prev_stall = '0;
    logic [15:0] prev_data [3];
    int          seq_ctr = 0;
    int          checks = 0;
    int          fails = 0;

    // Flit layout used by the bench: {seq[10:0], src[1:0], dst[1:0], valid}.
    function automatic logic [15:0] mk(int dst, int src, int seq);
        return {11'(seq), 2'(src), 2'(dst), 1'b1};
    endfunction

    function automatic int ref_route(int dst);
        if (dst == int'(LOCAL_IP)) return 2;
        if (dst > int'(LOCAL_IP)) return 0;
        return 1;
    endfunction

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endfunction

    function automatic void model_push(int p, logic [15:0] f);
        int o;
        if (f[0] == 1'b0) return;
        o = ref_route(int'(f[2:1]));
        if ((p == 0 && o == 0) || (p == 1 && o == 1)) begin
            err_model[p] = 1'b1;
        end else begin
            exp_q[p*3 + o].push_back(f);
            sent_cyc[int'(f[15:5])] = cyc;
        end
    endfunction

    function automatic void deliver(int o, logic [15:0] d);
        int   src;
        int   seq;
        logic [15:0] e;
        rec_t r;
        src = int'(d[4:3]);
        seq = int'(d[15:5]);
        checks++;
        if (src > 2) begin
            fails++;
            $display("FAIL out%0d_src: got flit %h with source tag %0d, required tag 0..2", o, d, src);
        end else if (exp_q[src*3 + o].size() == 0) begin
            fails++;
            $display("FAIL out%0d_unexpected: got flit %h, required no flit", o, d);
        end else begin
            e = exp_q[src*3 + o].pop_front();
            if (d !== e) begin
                fails++;
                $display("FAIL out%0d_data: got %h, required %h", o, d, e);
            end
        end
        r.src = src;
        r.seq = seq;
        r.cyc = cyc;
        r.lat = sent_cyc.exists(seq) ? cyc - sent_cyc[seq] : -1;
        log_q[o].push_back(r);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            foreach (exp_q[i]) exp_q[i].delete();
            err_model  = '0;
            prev_stall = '0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (prev_stall[o]) begin
                    checks++;
                    if (!out_valid[o] || out_data[o*16 +: 16] !== prev_data[o]) begin
                        fails++;
                        $display("FAIL out%0d_stall_hold: got valid=%0b data=%h, required valid=1 data=%h",
                                 o, out_valid[o], out_data[o*16 +: 16], prev_data[o]);
                    end
                end
                if (out_valid[o] && out_ready[o]) deliver(o, out_data[o*16 +: 16]);
                prev_stall[o] = out_valid[o] && !out_ready[o];
                prev_data[o]  = out_data[o*16 +: 16];
            end
            for (int p = 0; p < 3; p++) begin
                if (in_valid[p] && in_ready[p]) model_push(p, in_data[p*16 +: 16]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] rdy);
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = rdy;
        tick();
        reset = 1'b0;
    endtask

    task automatic put_flit(input int p, input int dst);
        in_data[p*16 +: 16] = mk(dst, p, seq_ctr);
        in_valid[p]         = 1'b1;
        seq_ctr++;
    endtask

    // Holds each port's flit until accepted; acc counts accepted flits.
    task automatic stream(input logic [2:0] mask, input int d0, input int d1, input int d2,
                          input int n, output int acc);
        logic [2:0] took;
        took = '1;
        acc  = 0;
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < 3; p++) begin
                if (mask[p] && took[p]) put_flit(p, (p == 0) ? d0 : (p == 1) ? d1 : d2);
            end
            took = in_valid & in_ready;
            for (int p = 0; p < 3; p++) acc += int'(took[p]);
            tick();
        end
        in_valid = '0;
    endtask

    function automatic int pending();
        int n = 0;
        foreach (exp_q[i]) n += exp_q[i].size();
        return n;
    endfunction

    task automatic drain();
        int n = 0;
        @(negedge clk);
        #1;
        while ((pending() != 0 || out_valid != 3'b000) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            fails++;
            $display("FAIL drain: got %0d flits still expected after 200 cycles, required 0", pending());
        end
    endtask

    function automatic void clear_logs();
        foreach (log_q[i]) log_q[i].delete();
    endfunction

    function automatic int gaps(int o);
        int n = 0;
        foreach (log_q[o][i]) if (log_q[o][i].cyc != log_q[o][0].cyc + i) n++;
        return n;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int acc;
        int bad;
        logic [2:0]  took;
        logic [15:0] f;

        // Reset values and single uncontended flit L -> E.
        do_reset(3'b111);
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 7);
        chk("reset_err_uturn", int'(err_uturn), 0);
        clear_logs();
        tick();
        stream(3'b100, 0, 0, 2, 1, acc);
        drain();
        chk("single_count_e", log_q[0].size(), 1);
        chk("single_count_wl", log_q[1].size() + log_q[2].size(), 0);
        if (log_q[0].size() == 1) chk("single_latency", log_q[0][0].lat, 2);

        // E and L contend for W: strict alternation starting with E.
        do_reset(3'b111);
        clear_logs();
        stream(3'b101, 0, 0, 0, 4, acc);
        drain();
        chk("rr_count", log_q[1].size(), 8);
        bad = 0;
        foreach (log_q[1][i]) if (log_q[1][i].src != ((i % 2 == 0) ? 0 : 2)) bad++;
        chk("rr_alternation_errors", bad, 0);
        chk("rr_gaps", gaps(1), 0);

        // Backpressure on L: 1 in output register + DEPTH in FIFO.
        do_reset(3'b011);
        clear_logs();
        stream(3'b010, 0, 1, 0, 10, acc);
        chk("bp_accepted", acc, 5);
        chk("bp_in_ready_w", int'(in_ready[1]), 0);
        repeat (3) tick();
        out_ready = 3'b111;
        drain();
        chk("bp_delivered", log_q[2].size(), 5);

        // U-turn on E is dropped and flagged; the next legal flit still flows.
        do_reset(3'b111);
        clear_logs();
        stream(3'b001, 2, 0, 0, 1, acc);
        repeat (4) tick();
        chk("uturn_no_output", log_q[0].size() + log_q[1].size() + log_q[2].size(), 0);
        chk("uturn_flag", int'(err_uturn), 1);
        stream(3'b001, 1, 0, 0, 1, acc);
        drain();
        chk("uturn_next_on_l", log_q[2].size(), 1);
        chk("uturn_flag_sticky", int'(err_uturn), 1);

        // All three outputs busy in parallel every cycle.
        do_reset(3'b111);
        clear_logs();
        stream(3'b111, 0, 2, 1, 10, acc);
        drain();
        for (int o = 0; o < 3; o++) begin
            chk($sformatf("par_count_%0d", o), log_q[o].size(), 10);
            chk($sformatf("par_gaps_%0d", o), gaps(o), 0);
            if (log_q[o].size() > 0) chk($sformatf("par_latency_%0d", o), log_q[o][0].lat, 2);
        end

        // Reset with buffered flits and a set error flag discards everything.
        do_reset(3'b000);
        stream(3'b001, 3, 0, 0, 1, acc);
        stream(3'b111, 0, 2, 1, 4, acc);
        tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 3'b111;
        clear_logs();
        @(negedge clk);
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_in_ready", int'(in_ready), 7);
        chk("midreset_err_uturn", int'(err_uturn), 0);
        repeat (10) tick();
        chk("midreset_no_stale", log_q[0].size() + log_q[1].size() + log_q[2].size(), 0);

        // Random traffic with random backpressure and discarded marker-0 flits.
        do_reset(3'b111);
        clear_logs();
        took = '1;
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 3; p++) begin
                if (!(in_valid[p] && !took[p])) begin
                    if ($urandom_range(0, 9) < 6) begin
                        f = mk($urandom_range(0, 3), p, seq_ctr);
                        seq_ctr++;
                        if ($urandom_range(0, 9) == 0) f[0] = 1'b0;
                        in_data[p*16 +: 16] = f;
                        in_valid[p]         = 1'b1;
                    end else begin
                        in_valid[p] = 1'b0;
                    end
                end
            end
            for (int o = 0; o < 3; o++) out_ready[o] = ($urandom_range(0, 3) != 0);
            took = in_valid & in_ready;
            tick();
        end
        in_valid  = '0;
        out_ready = 3'b111;
        drain();
        chk("random_err_uturn", int'(err_uturn), int'(err_model));
        chk("random_delivered_any", int'(log_q[0].size() > 0 && log_q[1].size() > 0 && log_q[2].size() > 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
